// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 frame scanner.
package hub75_pkg;

  localparam int unsigned SCAN_ROWS = 32;
  localparam int unsigned PLANES    = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    SHOW
  } scan_state_t;

  // Pick one bit-plane out of a pixel as {r, g, b}.
  function automatic logic [2:0] plane_bits(rgb444_t px, logic [1:0] plane);
    return {px.r[plane], px.g[plane], px.b[plane]};
  endfunction

endpackage

// File: rtl/hub75_frame_scan_bcm_timer.sv
// Binary-code-modulation display timer: loads BASE_TICKS << plane and
// flags the last cycle of the display window.
module bcm_timer #(
  parameter int unsigned BASE_TICKS = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [1:0] plane_i,
  output logic       done_o
);

  localparam int unsigned CNT_W = $clog2(BASE_TICKS * 8) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on request, otherwise count down while running, stopping at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(BASE_TICKS) << plane_i;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one marks the final display cycle, giving exactly N cycles.
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hub75_frame_scan.sv
// HUB75 1/32-scan driver: reads pixels from a dual-port buffer and scans
// all row pairs and bit-planes once per frame, pulsing frame_done at the end.
module hub75_frame_scan
  import hub75_pkg::*;
#(
  parameter int unsigned COLS       = 128,
  parameter int unsigned ROWS       = 64,
  parameter int unsigned BASE_TICKS = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  output logic [12:0] rd_addr_top,
  output logic [12:0] rd_addr_bot,
  input  logic [11:0] rd_data_top,
  input  logic [11:0] rd_data_bot,
  output logic [5:0]  panel_rgb,
  output logic        panel_clk,
  output logic        panel_lat,
  output logic        panel_oe_n,
  output logic [4:0]  panel_addr,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned HALF_ROWS = ROWS / 2;
  localparam int unsigned SHIFT_LEN = 2 * COLS + 2;
  localparam int unsigned SC_W      = $clog2(SHIFT_LEN);

  scan_state_t     state_q, state_d;
  logic [4:0]      row_q, row_d;
  logic [1:0]      plane_q, plane_d;
  logic [SC_W-1:0] scnt_q, scnt_d;
  logic [6:0]      col;
  logic            frame_end;
  logic            show_done;

  logic [5:0]      rgb_q, rgb_d;
  logic            pclk_q, pclk_d;
  logic            lat_q, lat_d;
  logic            oe_n_q, oe_n_d;
  logic [4:0]      addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            fd_q, fd_d;

  // Two SHIFT cycles per column: even cycles issue reads, odd ones clock.
  assign col = 7'(scnt_q >> 1);

  assign rd_addr_top = (state_q == SHIFT) ? {1'b0, row_q, col} : '0;
  assign rd_addr_bot = (state_q == SHIFT) ? {6'(row_q) + 6'(HALF_ROWS), col} : '0;

  bcm_timer #(
    .BASE_TICKS(BASE_TICKS)
  ) u_timer (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .load_i (state_q == LATCH),
    .run_i  (state_q == SHOW),
    .plane_i(plane_q),
    .done_o (show_done)
  );

  // State and scan counters.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      scnt_q  <= scnt_d;
    end
  end

  // Next-state and counter advance; en only matters in IDLE and at frame end.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    plane_d   = plane_q;
    scnt_d    = scnt_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHIFT;
          row_d   = '0;
          plane_d = '0;
          scnt_d  = '0;
        end
      end
      SHIFT: begin
        if (scnt_q == SC_W'(SHIFT_LEN - 1)) begin
          state_d = BLANK;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      BLANK: state_d = LATCH;
      LATCH: state_d = SHOW;
      SHOW: begin
        if (show_done) begin
          state_d = SHIFT;
          if (plane_q == 2'(PLANES - 1)) begin
            plane_d = '0;
            if (row_q == 5'(SCAN_ROWS - 1)) begin
              row_d     = '0;
              frame_end = 1'b1;
              if (!en) state_d = IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Panel output next values; decoded from state_d so strobes align with states.
  always_comb begin
    oe_n_d = (state_d != SHOW);
    lat_d  = (state_d == LATCH);
    busy_d = (state_d != IDLE);
    fd_d   = frame_end;
    pclk_d = 1'b0;
    rgb_d  = rgb_q;
    addr_d = addr_q;
    if ((state_q == SHIFT) && (scnt_q >= SC_W'(2))) begin
      if (scnt_q[0]) begin
        pclk_d = 1'b1;
      end else begin
        rgb_d = {plane_bits(rgb444_t'(rd_data_top), plane_q),
                 plane_bits(rgb444_t'(rd_data_bot), plane_q)};
      end
    end
    if (state_q == BLANK) begin
      addr_d = row_q;
    end
  end

  // Registered panel outputs; reset blanks the panel and drops any latch.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rgb_q  <= '0;
      pclk_q <= 1'b0;
      lat_q  <= 1'b0;
      oe_n_q <= 1'b1;
      addr_q <= '0;
      busy_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      pclk_q <= pclk_d;
      lat_q  <= lat_d;
      oe_n_q <= oe_n_d;
      addr_q <= addr_d;
      busy_q <= busy_d;
      fd_q   <= fd_d;
    end
  end

  assign panel_rgb  = rgb_q;
  assign panel_clk  = pclk_q;
  assign panel_lat  = lat_q;
  assign panel_oe_n = oe_n_q;
  assign panel_addr = addr_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hub75_frame_scan.sv
// Self-checking bench for hub75_frame_scan with a 2-cycle-latency pixel buffer.
`timescale 1ns/1ps
module tb_hub75_frame_scan;

  localparam int COLS      = 128;
  localparam int ROWS      = 64;
  localparam int BASE      = 64;
  localparam int SEG0      = 2 * COLS + 4;
  localparam int ROW_CYC   = 4 * SEG0 + 15 * BASE;
  localparam int FRAME_CYC = 32 * ROW_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [12:0] at, ab;
  logic [11:0] dt = '0, db = '0, dt1 = '0, db1 = '0;
  logic [5:0]  rgb;
  logic        pclk, lat, oe_n, busy, fd;
  logic [4:0]  paddr;

  logic [11:0] mem [0:8191];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int S = 0;
  bit model_on = 1'b0;
  bit mon_on = 1'b0;

  hub75_frame_scan #(
    .COLS(COLS),
    .ROWS(ROWS),
    .BASE_TICKS(BASE)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .en(en),
    .rd_addr_top(at), .rd_addr_bot(ab),
    .rd_data_top(dt), .rd_data_bot(db),
    .panel_rgb(rgb), .panel_clk(pclk), .panel_lat(lat), .panel_oe_n(oe_n),
    .panel_addr(paddr), .busy(busy), .frame_done(fd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dt1 <= mem[at];
    db1 <= mem[ab];
    dt  <= dt1;
    db  <= db1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Position inside a frame: row pair, bit-plane, offset within row-plane.
  function automatic void locate(input int t, output int r, output int p, output int w);
    int v;
    r = t / ROW_CYC;
    v = t % ROW_CYC;
    p = 0;
    while (v >= SEG0 + (BASE << p)) begin
      v = v - (SEG0 + (BASE << p));
      p++;
    end
    w = v;
  endfunction

  // Behavioural model: every output each cycle of a running frame.
  always @(negedge clk) begin
    int t, r, p, w, c;
    logic [11:0] pt, pb;
    logic [5:0]  er;
    if (model_on) begin
      t = cyc - S;
      if (t >= 0 && t < FRAME_CYC) begin
        locate(t, r, p, w);
        chk("busy", busy, 1);
        chk("frame_done", fd, 0);
        chk("oe_n", oe_n, (w >= SEG0) ? 1'b0 : 1'b1);
        chk("lat", lat, (w == SEG0 - 1) ? 1'b1 : 1'b0);
        chk("pclk", pclk, (w >= 4 && w <= 2 * COLS + 2 && (w % 2) == 0) ? 1'b1 : 1'b0);
        if (w < 2 * COLS && (w % 2) == 0) begin
          chk("addr_top", at, r * 128 + w / 2);
          chk("addr_bot", ab, (r + 32) * 128 + w / 2);
        end
        if (w >= 3 && w <= 2 * COLS + 2) begin
          c  = (w - 3) / 2;
          pt = mem[r * 128 + c];
          pb = mem[(r + 32) * 128 + c];
          er = {pt[8 + p], pt[4 + p], pt[p], pb[8 + p], pb[4 + p], pb[p]};
          chk("rgb", rgb, er);
        end
        if (w >= SEG0 - 1) chk("panel_addr", paddr, r);
      end
    end
  end

  // Literal checks over the first frame: widths, latch order, edges, pixels.
  bit oe_prev = 1'b1, clk_prev = 1'b0, lat_prev = 1'b0;
  int run_len = 0, edges = 0, lat_n = 0, fd_cyc = -1;
  int show_w[$];
  always @(negedge clk) begin
    if (mon_on && cyc >= S) begin
      if (!oe_n) begin
        if (oe_prev) begin
          chk("lat_before_show", lat_prev, 1);
          run_len = 1;
        end else begin
          run_len++;
        end
      end else if (!oe_prev && show_w.size() < 4) begin
        show_w.push_back(run_len);
      end
      if (pclk && !clk_prev) begin
        edges++;
        if (lat_n / 4 == 0)
          chk("row0_edge_rgb", rgb, (edges == 6 && (lat_n % 2) == 0) ? 6'b010000 : 6'b000000);
        else
          chk("edge_rgb", rgb, 6'b100100);
      end
      if (lat) begin
        chk("lat_addr", paddr, lat_n / 4);
        chk("edges_per_shift", edges, 128);
        edges = 0;
        lat_n++;
      end
      if (fd && fd_cyc < 0) fd_cyc = cyc;
    end
    oe_prev  = oe_n;
    clk_prev = pclk;
    lat_prev = lat;
  end

  initial begin
    int n;
    for (int i = 0; i < 8192; i++)
      mem[i] = ((i / 128) == 0 || (i / 128) == 32) ? 12'h000 : 12'hF00;
    mem[5] = 12'h050;

    repeat (3) @(negedge clk);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fd", fd, 0);
    chk("rst_lat", lat, 0);
    chk("rst_pclk", pclk, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_addr_top", at, 0);
    chk("rst_addr_bot", ab, 0);

    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pclk) n++;
      if (i % 100 == 0) begin
        chk("idle_oe_n", oe_n, 1);
        chk("idle_busy", busy, 0);
      end
    end
    chk("idle_pclk_cycles", n, 0);

    // Run 1: full frame, en dropped during row 10.
    @(negedge clk);
    en = 1'b1;
    S = cyc + 1;
    model_on = 1'b1;
    mon_on = 1'b1;
    chk("busy_before_start", busy, 0);
    repeat (S + 10 * ROW_CYC + 500 - cyc) @(negedge clk);
    en = 1'b0;
    repeat (S + FRAME_CYC - cyc) @(negedge clk);
    chk("frame_end_fd", fd, 1);
    chk("frame_end_busy", busy, 0);
    chk("frame_end_oe_n", oe_n, 1);
    @(negedge clk);
    chk("fd_one_cycle", fd, 0);
    chk("idle_after_frame", busy, 0);
    model_on = 1'b0;
    mon_on = 1'b0;
    for (int i = 0; i < 4; i++)
      chk("show_width", (i < show_w.size()) ? show_w[i] : -1, 64 << i);
    chk("frame_done_cycle", fd_cyc - S, 64000);
    chk("latch_count", lat_n, 128);

    // Run 2: reset during SHOW of row 7, then restart.
    repeat (5) @(negedge clk);
    en = 1'b1;
    S = cyc + 1;
    model_on = 1'b1;
    repeat (S + 7 * ROW_CYC + 300 - cyc) @(negedge clk);
    model_on = 1'b0;
    chk("in_show_row7", oe_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe_n", oe_n, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_lat", lat, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    S = cyc + 1;
    model_on = 1'b1;
    repeat (S + SEG0 - 1 - cyc) @(negedge clk);
    chk("restart_lat", lat, 1);
    chk("restart_row0", paddr, 0);
    repeat (S + ROW_CYC + 100 - cyc) @(negedge clk);
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
